serial_frame_aligner: RTL and testbench

- Upstream neighbour of the pixel-data packer.
- Takes the chip's single-bit serial data output and recovers bit and byte alignment by hunting for the K28.5-style header byte 0xBC.
- Verifies that the header recurs every FRAME_BYTES bytes, then emits aligned bytes as an 8-bit bus (fd[7:0]) with a valid strobe and a start-of-frame flag, which the packer consumes.
- Tracks lock and loss of lock, and counts header errors.

---
 rtl/pixel_readout_pkg.sv | 14 +
 rtl/frame_lock_fsm.sv | 94 +++++++++
 rtl/serial_frame_aligner.sv | 120 ++++++++++++
 tb/tb_serial_frame_aligner.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pixel_readout_pkg.sv
// Shared definitions for the pixel readout chain: header byte, frame size
// and the frame-lock state encoding.
package pixel_readout_pkg;

  localparam logic [7:0] HEADER_K285     = 8'hBC;
  localparam int         FRAME_BYTES_DEF = 48;

  typedef enum logic [2:0] {
    HUNT   = 3'b001,
    VERIFY = 3'b010,
    LOCKED = 3'b100
  } lock_state_e;

endpackage

// File: rtl/frame_lock_fsm.sv
// Frame lock state machine: qualifies repeated headers into lock and
// counts consecutive misses to drop lock again.
module frame_lock_fsm
  import pixel_readout_pkg::*;
#(
  parameter int LOCK_COUNT   = 3,
  parameter int UNLOCK_COUNT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hdr_match,
  input  logic        hdr_chk,
  output lock_state_e state,
  output logic        locked,
  output logic        realign
);

  localparam int CNT_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  lock_state_e      state_q;
  logic [CNT_W-1:0] good_q;
  logic [CNT_W-1:0] miss_q;
  logic             locked_q;
  logic             realign_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= HUNT;
      good_q    <= '0;
      miss_q    <= '0;
      locked_q  <= 1'b0;
      realign_q <= 1'b0;
    end else begin
      realign_q <= 1'b0;
      unique case (state_q)
        HUNT: begin
          // Any bit phase is acceptable here; the top re-phases its counters.
          if (hdr_match) begin
            good_q <= CNT_W'(1);
            if (LOCK_COUNT == 1) begin
              state_q  <= LOCKED;
              locked_q <= 1'b1;
              miss_q   <= '0;
            end else begin
              state_q <= VERIFY;
            end
          end
        end
        VERIFY: begin
          if (hdr_chk) begin
            if (hdr_match) begin
              good_q <= good_q + 1'b1;
              if (good_q == CNT_W'(LOCK_COUNT - 1)) begin
                state_q  <= LOCKED;
                locked_q <= 1'b1;
                miss_q   <= '0;
              end
            end else begin
              good_q  <= '0;
              state_q <= HUNT;
            end
          end
        end
        LOCKED: begin
          if (hdr_chk) begin
            if (hdr_match) begin
              miss_q <= '0;
            end else if (miss_q == CNT_W'(UNLOCK_COUNT - 1)) begin
              miss_q    <= '0;
              good_q    <= '0;
              state_q   <= HUNT;
              locked_q  <= 1'b0;
              realign_q <= 1'b1;
            end else begin
              miss_q <= miss_q + 1'b1;
            end
          end
        end
        default: begin
          state_q  <= HUNT;
          good_q   <= '0;
          miss_q   <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign locked  = locked_q;
  assign realign = realign_q;

endmodule

// File: rtl/serial_frame_aligner.sv
// Recovers bit/byte alignment of the serial chip stream from the recurring
// header byte and emits aligned bytes with valid and start-of-frame flags.
module serial_frame_aligner
  import pixel_readout_pkg::*;
#(
  parameter logic [7:0] HEADER       = HEADER_K285,
  parameter int         FRAME_BYTES  = FRAME_BYTES_DEF,
  parameter int         LOCK_COUNT   = 3,
  parameter int         UNLOCK_COUNT = 2,
  parameter int         ERR_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 sdin,
  input  logic                 clr_err,
  output logic [7:0]           fd,
  output logic                 fd_valid,
  output logic                 sof,
  output logic                 locked,
  output logic                 realign,
  output logic [ERR_WIDTH-1:0] err_cnt
);

  localparam int                IDX_W    = $clog2(FRAME_BYTES + 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  function automatic logic [ERR_WIDTH-1:0] sat_inc(input logic [ERR_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [7:0]           shreg_q, shreg_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     byte_idx_q, byte_idx_d;
  logic [7:0]           fd_q, fd_d;
  logic                 fd_valid_q, fd_valid_d;
  logic                 sof_q, sof_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;

  logic [7:0]           check;
  logic                 boundary;
  logic [IDX_W-1:0]     idx_next;
  logic                 hdr_match;
  logic                 hdr_chk;
  lock_state_e          state;

  always_comb begin
    check     = {shreg_q[6:0], sdin};
    boundary  = (bit_cnt_q == 3'd7);
    hdr_match = (check == HEADER);
    idx_next  = byte_idx_q;
    if (boundary) begin
      idx_next = (byte_idx_q == LAST_IDX) ? '0 : byte_idx_q + 1'b1;
    end
    hdr_chk    = boundary && (idx_next == '0);

    shreg_d    = check;
    bit_cnt_d  = bit_cnt_q + 3'd1;
    byte_idx_d = idx_next;
    // A header found while hunting defines the new byte phase and frame index 0.
    if (state == HUNT && hdr_match) begin
      bit_cnt_d  = 3'd0;
      byte_idx_d = '0;
    end

    fd_d       = fd_q;
    fd_valid_d = 1'b0;
    sof_d      = 1'b0;
    err_d      = err_q;
    if (state == LOCKED && boundary) begin
      fd_d       = check;
      fd_valid_d = 1'b1;
      sof_d      = hdr_chk && hdr_match;
      if (hdr_chk && !hdr_match) begin
        err_d = sat_inc(err_q);
      end
    end
    if (clr_err) begin
      err_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      byte_idx_q <= '0;
      fd_q       <= '0;
      fd_valid_q <= 1'b0;
      sof_q      <= 1'b0;
      err_q      <= '0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_idx_q <= byte_idx_d;
      fd_q       <= fd_d;
      fd_valid_q <= fd_valid_d;
      sof_q      <= sof_d;
      err_q      <= err_d;
    end
  end

  frame_lock_fsm #(
    .LOCK_COUNT  (LOCK_COUNT),
    .UNLOCK_COUNT(UNLOCK_COUNT)
  ) u_lock_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .hdr_match(hdr_match),
    .hdr_chk  (hdr_chk),
    .state    (state),
    .locked   (locked),
    .realign  (realign)
  );

  assign fd       = fd_q;
  assign fd_valid = fd_valid_q;
  assign sof      = sof_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_serial_frame_aligner.sv
// Frame-level directed bench for serial_frame_aligner: each table row sends
// one 48-byte frame and states what the aligner must emit during it.
module tb_serial_frame_aligner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sdin = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  fd;
  logic        fd_valid;
  logic        sof;
  logic        locked;
  logic        realign;
  logic [15:0] err_cnt;

  serial_frame_aligner #(
    .HEADER      (8'hBC),
    .FRAME_BYTES (48),
    .LOCK_COUNT  (3),
    .UNLOCK_COUNT(2),
    .ERR_WIDTH   (16)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sdin    (sdin),
    .clr_err (clr_err),
    .fd      (fd),
    .fd_valid(fd_valid),
    .sof     (sof),
    .locked  (locked),
    .realign (realign),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] hdr;
    bit         bc17;
    int         drop_bit;
    int         clr_bit;
    int         exp_valid;
    int         exp_sof;
    int         exp_real;
    int         exp_err;
    bit         exp_locked;
    int         first_b;
  } frame_vec_t;

  frame_vec_t vecs[27];

  int n_checks = 0;
  int n_pass   = 0;

  int         m_valid = 0;
  int         m_sof   = 0;
  int         m_real  = 0;
  logic [8:0] m_bytes[$];

  always @(posedge clk) begin
    #1;
    if (fd_valid) begin
      m_valid++;
      m_bytes.push_back({sof, fd});
    end
    if (sof) m_sof++;
    if (realign) m_real++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: run still active at %0t, required to end earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic logic [7:0] frame_byte(input frame_vec_t v, input int j);
    if (j == 0) return v.hdr;
    if (v.bc17 && j == 17) return 8'hBC;
    return 8'(j - 1);
  endfunction

  task automatic send_bit(input logic b);
    sdin = b;
    @(posedge clk);
    #2;
  endtask

  task automatic send_bits(input frame_vec_t v, input int nbits);
    logic [7:0] b;
    for (int i = 0; i < nbits; i++) begin
      if (i == v.drop_bit) continue;
      b = frame_byte(v, i / 8);
      clr_err = (i == v.clr_bit);
      send_bit(b[7 - (i % 8)]);
    end
    clr_err = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " fd"}, int'(fd), 0);
    check({tag, " fd_valid"}, int'(fd_valid), 0);
    check({tag, " sof"}, int'(sof), 0);
    check({tag, " locked"}, int'(locked), 0);
    check({tag, " realign"}, int'(realign), 0);
    check({tag, " err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic run_frame(input int k);
    frame_vec_t v;
    int bv, bs, br, bq, nv, bad, first_bad, j;
    logic [8:0] exp_b, got_b, fb_exp, fb_got;
    v  = vecs[k];
    bv = m_valid;
    bs = m_sof;
    br = m_real;
    bq = m_bytes.size();
    send_bits(v, 384);
    nv = m_valid - bv;
    check($sformatf("f%0d fd_valid count", k), nv, v.exp_valid);
    check($sformatf("f%0d sof count", k), m_sof - bs, v.exp_sof);
    check($sformatf("f%0d realign cycles", k), m_real - br, v.exp_real);
    check($sformatf("f%0d err_cnt", k), int'(err_cnt), v.exp_err);
    check($sformatf("f%0d locked", k), int'(locked), int'(v.exp_locked));
    if (v.first_b >= 0) begin
      bad = 0;
      first_bad = -1;
      fb_exp = '0;
      fb_got = '0;
      for (int n = 0; n < nv; n++) begin
        j = v.first_b + n;
        exp_b = (j < 48) ? {(j == 0 && v.hdr == 8'hBC), frame_byte(v, j)} : 9'h1FF;
        got_b = m_bytes[bq + n];
        if (got_b != exp_b) begin
          if (bad == 0) begin
            first_bad = j;
            fb_exp = exp_b;
            fb_got = got_b;
          end
          bad++;
        end
      end
      n_checks++;
      if (bad == 0) n_pass++;
      else $display("FAIL f%0d bytes: %0d wrong, first at index %0d got {sof,fd}=%h expected %h",
                    k, bad, first_bad, fb_got, fb_exp);
    end
  endtask

  initial begin
    //          hdr    bc17 drop clr  vld sof rea err lck first
    vecs[0]  = '{8'hBC, 0, -1, -1,  0, 0, 0, 0, 0, -1};
    vecs[1]  = '{8'hBC, 0, -1, -1,  0, 0, 0, 0, 0, -1};
    vecs[2]  = '{8'hBC, 0, -1, -1, 47, 0, 0, 0, 1,  1};
    vecs[3]  = '{8'hBC, 0, -1, -1, 48, 1, 0, 0, 1,  0};
    vecs[4]  = '{8'hBD, 0, -1, -1, 48, 0, 0, 1, 1,  0};
    vecs[5]  = '{8'hBD, 0, -1, -1,  1, 0, 1, 2, 0,  0};
    vecs[6]  = '{8'hBC, 0, -1, -1,  0, 0, 0, 2, 0, -1};
    vecs[7]  = '{8'hBC, 0, -1, -1,  0, 0, 0, 2, 0, -1};
    vecs[8]  = '{8'hBC, 0, -1, -1, 47, 0, 0, 2, 1,  1};
    vecs[9]  = '{8'hBC, 1, -1, -1, 48, 1, 0, 2, 1,  0};
    vecs[10] = '{8'hBD, 0, -1, -1, 48, 0, 0, 3, 1,  0};
    vecs[11] = '{8'hBC, 0, -1, -1, 48, 1, 0, 3, 1,  0};
    vecs[12] = '{8'hBD, 0, -1, -1, 48, 0, 0, 4, 1,  0};
    vecs[13] = '{8'hBC, 0, -1, -1, 48, 1, 0, 4, 1,  0};
    vecs[14] = '{8'hBC, 0, 160, -1, 47, 1, 0, 4, 1, -1};
    vecs[15] = '{8'hBC, 0, -1, -1, 48, 0, 0, 5, 1, -1};
    vecs[16] = '{8'hBC, 0, -1, -1,  2, 0, 1, 6, 0, -1};
    vecs[17] = '{8'hBC, 0, -1, -1,  0, 0, 0, 6, 0, -1};
    vecs[18] = '{8'hBC, 0, -1, -1,  0, 0, 0, 6, 0, -1};
    vecs[19] = '{8'hBC, 0, -1, -1, 47, 0, 0, 6, 1,  1};
    vecs[20] = '{8'hBC, 0, -1, -1, 48, 1, 0, 6, 1,  0};
    vecs[21] = '{8'hBC, 0, -1, -1,  0, 0, 0, 0, 0, -1};
    vecs[22] = '{8'hBC, 0, -1, -1,  0, 0, 0, 0, 0, -1};
    vecs[23] = '{8'hBC, 0, -1, -1, 47, 0, 0, 0, 1,  1};
    vecs[24] = '{8'hBD, 0, -1,  7, 48, 0, 0, 0, 1,  0};
    vecs[25] = '{8'hBC, 0, -1, -1, 48, 1, 0, 0, 1,  0};
    vecs[26] = '{8'hBD, 0, -1, -1, 48, 0, 0, 1, 1,  0};

    rst_n = 1'b0;
    send_bit(1'b0);
    send_bit(1'b1);
    check_zero("reset");
    rst_n = 1'b1;

    // Arbitrary bit offset before the first header.
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));

    for (int k = 0; k <= 20; k++) run_frame(k);

    // Abort mid-frame on what would have been a byte boundary.
    send_bits(vecs[3], 103);
    rst_n = 1'b0;
    send_bit(1'b1);
    check_zero("mid-frame reset");
    rst_n = 1'b1;

    for (int k = 21; k <= 26; k++) run_frame(k);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
